// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter: round-robin, break-before-make ownership of a shared pad group, Wishbone configured.
// Define PAD_ARB_TIMEOUT_EN to build the hold timeout (TIMEOUT register, counter, TO_STICKY, timeout_irq_o).
module pad_share_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TIMEOUT_W = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             busy_o,
  output logic             timeout_irq_o
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_TIMEOUT = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  state_t               state, state_nxt;
  logic                 ctrl_en, ctrl_force;
  logic [2:0]           force_idx;
  logic [N_REQ-1:0]     mask;
  logic [2:0]           rr_ptr, owner, grant_idx, pick_idx;
  logic                 forced, force_ok, pick_valid, exit_grant;
  logic [N_REQ-1:0]     gnt_nxt;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic                 to_sticky, timeout_hit;
  logic [7:0]           req8, mask8, elig8;
  logic [3:0]           cand;
  logic                 wb_hit, addr_match, reg_wr;
  logic [1:0]           reg_sel;
  logic [31:0]          rd_data;
  logic                 unused_bits;

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

  // Wishbone: single-cycle ack; out-of-window addresses ack with zero data and no side effects.
  assign wb_hit     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign addr_match = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel    = wbs_adr_i[3:2];
  assign reg_wr     = wb_hit & wbs_we_i & addr_match;

  // NOTE: every always_ff uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_hit;
      wbs_dat_o <= (wb_hit && !wbs_we_i && addr_match) ? rd_data : '0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL:    rd_data = {21'b0, force_idx, 6'b0, ctrl_force, ctrl_en};
      REG_MASK:    rd_data = 32'(mask);
      REG_TIMEOUT: rd_data = 32'(timeout_q);
      REG_STATUS:  rd_data = {15'b0, to_sticky, 7'b0, busy_o, 8'(gnt_o)};
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_en    <= 1'b0;
      ctrl_force <= 1'b0;
      force_idx  <= '0;
      mask       <= '1;
    end else if (reg_wr) begin
      if (reg_sel == REG_CTRL) begin
        if (wbs_sel_i[0]) begin
          ctrl_en    <= wbs_dat_i[0];
          ctrl_force <= wbs_dat_i[1];
        end
        if (wbs_sel_i[1]) force_idx <= wbs_dat_i[10:8];
      end
      if (reg_sel == REG_MASK && wbs_sel_i[0]) mask <= wbs_dat_i[N_REQ-1:0];
    end
  end

`ifdef PAD_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] hold_cnt;
  logic [31:0]          timeout_wr;

  always_comb begin
    timeout_wr = 32'(timeout_q);
    for (int b = 0; b < 4; b++)
      if (wbs_sel_i[b]) timeout_wr[8*b +: 8] = wbs_dat_i[8*b +: 8];
  end

  assign timeout_hit = (state == GRANT) && !forced && (timeout_q != '0) &&
                       (hold_cnt == timeout_q - TIMEOUT_W'(1));

  // A timeout landing on the same edge as a W1C keeps the sticky bit set.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timeout_q     <= '0;
      hold_cnt      <= '0;
      to_sticky     <= 1'b0;
      timeout_irq_o <= 1'b0;
    end else begin
      if (reg_wr && reg_sel == REG_TIMEOUT) timeout_q <= timeout_wr[TIMEOUT_W-1:0];
      hold_cnt      <= (state == GRANT) ? hold_cnt + TIMEOUT_W'(1) : '0;
      timeout_irq_o <= timeout_hit;
      if (timeout_hit)
        to_sticky <= 1'b1;
      else if (reg_wr && reg_sel == REG_STATUS && wbs_sel_i[2] && wbs_dat_i[16])
        to_sticky <= 1'b0;
    end
  end
`else
  assign timeout_q     = '0;
  assign to_sticky     = 1'b0;
  assign timeout_hit   = 1'b0;
  assign timeout_irq_o = 1'b0;
`endif

  assign req8     = 8'(req_i);
  assign mask8    = 8'(mask);
  assign elig8    = req8 & mask8;
  assign force_ok = 32'(force_idx) < N_REQ;

  // Scan downwards so the last hit, the first eligible index at/after rr_ptr, wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (elig8[cand[2:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    if (forced)
      exit_grant = !ctrl_force || (force_idx != owner);
    else
      exit_grant = !req8[owner] || !mask8[owner] || !ctrl_en ||
                   (ctrl_force && (force_idx != owner)) || timeout_hit;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_force ? force_ok : (ctrl_en && pick_valid)) state_nxt = GRANT;
      GRANT:   if (exit_grant) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_idx = ctrl_force ? force_idx : pick_idx;
    gnt_nxt   = gnt_o;
    if (state_nxt != GRANT) gnt_nxt = '0;
    else if (state == IDLE) gnt_nxt = N_REQ'(8'd1 << grant_idx);
  end

  // Forced ownership never moves the round-robin pointer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gnt_o  <= '0;
      busy_o <= 1'b0;
      owner  <= '0;
      forced <= 1'b0;
      rr_ptr <= '0;
    end else begin
      gnt_o  <= gnt_nxt;
      busy_o <= |gnt_nxt;
      if (state == IDLE && state_nxt == GRANT) begin
        owner  <= grant_idx;
        forced <= ctrl_force;
      end
      if (state == GRANT && state_nxt == RECOVER && !forced)
        rr_ptr <= (owner == 3'(N_REQ - 1)) ? '0 : owner + 3'd1;
    end
  end

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Bench for pad_share_arbiter: grant scoreboard (owner + zero-gap length) fed by the scenario tasks,
// popped by a grant monitor; register and timing checks are inline in each task.
module tb_pad_share_arbiter;
  localparam int N_REQ = 4;
  localparam int GAP   = 2;   // zero cycles between owners: RECOVER, then IDLE decision
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_MASK = 32'h3000_0004;
  localparam logic [31:0] A_TOUT = 32'h3000_0008;
  localparam logic [31:0] A_STAT = 32'h3000_000C;
  localparam logic [31:0] A_BAD  = 32'h3000_0020;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]       sel = '0;
  logic [31:0]      wdat = '0, adr = '0;
  logic             ack;
  logic [31:0]      rdat;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] gnt;
  logic             busy, irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    int               gap;   // 0 = gap length not checked
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [N_REQ-1:0] prev_gnt = '0;
  int               zrun = 0;

  pad_share_arbiter #(.N_REQ(N_REQ), .TIMEOUT_W(16), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .req_i(req), .gnt_o(gnt), .busy_o(busy), .timeout_irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Grant monitor: every new non-zero grant must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
      zrun     = 0;
    end else begin
      if (gnt === '0) zrun++;
      else if (gnt !== prev_gnt) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_grant got=%b want=none", gnt);
        end else begin
          mon_e = sb.pop_front();
          if (gnt !== mon_e.gnt) begin
            bad++;
            $display("FAIL sb_grant got=%b want=%b", gnt, mon_e.gnt);
          end
          if (mon_e.gap != 0) begin
            total++;
            if (zrun != mon_e.gap) begin
              bad++;
              $display("FAIL grant_gap got=%0d want=%0d", zrun, mon_e.gap);
            end
          end
          total++;
          if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_on_grant got=%b want=1", busy);
          end
        end
        zrun = 0;
      end
      prev_gnt = gnt;
    end
  end

  task automatic expect_gnt(input logic [N_REQ-1:0] g, input int gap);
    exp_t e;
    e.gnt = g;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL wb_ack adr=%h got=%b want=1", a, ack);
    end
    r = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL wb_ack_len adr=%h got=%b want=0", a, ack);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_access(1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic wait_gnt(output logic [N_REQ-1:0] g);
    int n = 0;
    g = gnt;
    while (g === '0 && n < 30) begin
      @(posedge clk); #1;
      g = gnt;
      n++;
    end
    total++;
    if (g === '0) begin
      bad++;
      $display("FAIL wait_gnt got=%b want=nonzero", g);
    end
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    cyc_wait(3);
    rst = 1'b0;
    total++;
    if ({gnt, busy, irq, ack, rdat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b_%b_%b_%b_%h want=0", gnt, busy, irq, ack, rdat);
    end
    wb_read(A_MASK, r);
    total++; if (r !== 32'h0000_000F) begin bad++; $display("FAIL reset_mask got=%h want=0000000f", r); end
    wb_read(A_CTRL, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", r); end
    wb_read(A_TOUT, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_timeout got=%h want=0", r); end
    wb_read(A_STAT, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", r); end
  endtask

  task automatic test_basic();
    req = 4'b1010;
    expect_gnt(4'b0010, 0);
    wb_write(A_CTRL, 32'h1, 4'hF);
    wait_sb(10);
    expect_gnt(4'b1000, GAP);
    req = 4'b1000;
    wait_sb(10);
    req = 4'b0000;
    cyc_wait(3);
    total++;
    if (gnt !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_release got=%b/%b want=0000/0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] g;
    expect_gnt(4'b0001, 0);
    expect_gnt(4'b0010, GAP);
    expect_gnt(4'b0100, GAP);
    expect_gnt(4'b1000, GAP);
    expect_gnt(4'b0001, GAP);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      req = req & ~g;
      cyc_wait(1);
      if (k == 4) req = '0;
      else        req = req | g;
    end
    wait_sb(10);
    cyc_wait(3);
  endtask

`ifdef PAD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [N_REQ-1:0] g;
    logic [31:0]      r;
    int               n;
    wb_write(A_TOUT, 32'd5, 4'hF);
    expect_gnt(4'b0100, 0);
    req = 4'b0100;
    wait_gnt(g);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0100) break;
      n++;
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL timeout_hold got=%0d want=5", n); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL timeout_irq got=%b want=1", irq); end
    req = '0;
    cyc_wait(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL timeout_irq_len got=%b want=0", irq); end
    wait_sb(5);
    wb_read(A_STAT, r);
    total++; if (r !== 32'h0001_0000) begin bad++; $display("FAIL to_sticky got=%h want=00010000", r); end
    wb_write(A_STAT, 32'h0001_0000, 4'b0100);
    wb_read(A_STAT, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL to_sticky_w1c got=%h want=0", r); end
    wb_write(A_TOUT, 32'd0, 4'hF);
  endtask
`else
  task automatic test_timeout();
    logic [N_REQ-1:0] g;
    logic [31:0]      r;
    logic             irq_seen = 1'b0;
    wb_write(A_TOUT, 32'd5, 4'hF);
    wb_read(A_TOUT, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL timeout_disabled_reg got=%h want=0", r); end
    expect_gnt(4'b0100, 0);
    req = 4'b0100;
    wait_gnt(g);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      irq_seen = irq_seen | irq;
    end
    total++;
    if (gnt !== 4'b0100 || irq_seen !== 1'b0) begin
      bad++;
      $display("FAIL timeout_disabled_hold got=%b/%b want=0100/0", gnt, irq_seen);
    end
    wb_read(A_STAT, r);
    total++; if (r !== 32'h0000_0104) begin bad++; $display("FAIL status_owned got=%h want=00000104", r); end
    req = '0;
    wait_sb(5);
    cyc_wait(3);
  endtask
`endif

  task automatic test_force();
    logic [N_REQ-1:0] g;
    logic             held = 1'b1;
    int               zeros = 0;
    expect_gnt(4'b0001, 0);
    req = 4'b0001;
    wait_sb(10);
    expect_gnt(4'b1000, GAP);
    wb_write(A_CTRL, 32'h0000_0303, 4'hF);
    wait_sb(20);
    req = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b1000) held = 1'b0;
    end
    total++;
    if (held !== 1'b1) begin bad++; $display("FAIL force_hold got=%b want=1000", gnt); end
    wb_write(A_CTRL, 32'h1, 4'hF);
    cyc_wait(2);
    total++;
    if (gnt !== '0) begin bad++; $display("FAIL force_release got=%b want=0000", gnt); end
    expect_gnt(4'b0010, 0);
    req = 4'b1111;
    wait_gnt(g);
    req = '0;
    wait_sb(5);
    cyc_wait(3);
    wb_write(A_CTRL, 32'h0000_0502, 4'hF);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (gnt === '0) zeros++;
    end
    total++;
    if (zeros != 8) begin bad++; $display("FAIL force_bad_idx got=%0d want=8 zero cycles", zeros); end
    req = '0;
    wb_write(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_mask_badaddr();
    logic [31:0] r;
    int          zeros = 0;
    wb_write(A_MASK, 32'h0, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (gnt === '0) zeros++;
    end
    total++;
    if (zeros != 8) begin bad++; $display("FAIL mask_block got=%0d want=8 zero cycles", zeros); end
    wb_write(A_BAD, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_MASK, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL badaddr_mask got=%h want=0", r); end
    wb_read(A_CTRL, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL badaddr_ctrl got=%h want=1", r); end
    wb_read(A_BAD, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL badaddr_read got=%h want=0", r); end
    wb_write(A_MASK, 32'hFFFF_FFFF, 4'b1110);
    wb_read(A_MASK, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL byte_sel_mask got=%h want=0", r); end
    expect_gnt(4'b0100, 0);
    wb_write(A_MASK, 32'hF, 4'b0001);
    wait_sb(10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_grant got=%b/%b want=0000/0", gnt, busy);
    end
    req = '0;
    cyc_wait(2);
    rst = 1'b0;
    wb_read(A_MASK, r);
    total++; if (r !== 32'h0000_000F) begin bad++; $display("FAIL mask_after_reset got=%h want=0000000f", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_force();
    test_mask_badaddr();
    cyc_wait(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
